// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single port of a `memory` instance between the data
//   load/store path (port 0) and the instruction-fetch path (port 1).
//   Every access is a fixed MEM_LAT-cycle chip-select window followed by a
//   one-cycle DONE state. When both ports ask at once, the port not served
//   last wins, so neither requester can starve the other.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req0/req1             level requests (0 = data, 1 = fetch)
//   rw0/rw1               1 = read, 0 = write
//   addr0/addr1           access addresses
//   wdata0/wdata1         write data
//   gnt0/gnt1             port owns the memory (ACCESS and DONE)
//   done0/done1           one-cycle completion pulse
//   rdata                 last read result, valid while a done is high
//   mem_addr/mem_wdata    memory address / write data
//   mem_rdata             memory read data
//   chip_s/out_en/RW      memory chip select / output enable / direction
module mem_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              chip_s,
  output logic              out_en,
  output logic              RW
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                win;        // index of the port being served
  logic                last;       // index of the port served most recently
  logic                lat_rw;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                pick;

  // On a tie the port that was not served last wins; otherwise whoever asks.
  assign pick = (req0 && req1) ? ~last : req1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      win       <= 1'b0;
      last      <= 1'b1;
      lat_rw    <= 1'b0;
      // NOTE: the request latches are reset as well even though the outputs
      // are gated by state, so a reset leaves no stale address or data behind.
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            win       <= pick;
            last      <= pick;
            lat_rw    <= pick ? rw1    : rw0;
            lat_addr  <= pick ? addr1  : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
            cnt       <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (lat_rw) begin
            // Last cycle of the window: the memory data is valid now.
            rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode purely from registered state, so there is no path from
  // any input to any output.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    chip_s    = 1'b0;
    out_en    = 1'b0;
    RW        = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = ACCESS;
      end
      ACCESS: begin
        gnt0      = ~win;
        gnt1      = win;
        chip_s    = 1'b1;
        out_en    = lat_rw;
        RW        = lat_rw;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        gnt0      = ~win;
        gnt1      = win;
        done0     = ~win;
        done1     = win;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
